// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector read sequencer:
// sd unit command encodings, CMD17 framing bytes and result codes.
package sd_pkg;

   typedef enum logic [1:0] {
      SD_XFER = 2'd0,
      SD_CSLO = 2'd1,
      SD_CSHI = 2'd2
   } sd_op_e;

   typedef enum logic [2:0] {
      ERR_OK        = 3'd0,
      ERR_NO_R1     = 3'd1,
      ERR_R1        = 3'd2,
      ERR_TOKEN_TMO = 3'd3,
      ERR_TOKEN     = 3'd4,
      ERR_SPI_TMO   = 3'd5
   } err_e;

   localparam logic [7:0] CMD17       = 8'h51;
   localparam logic [7:0] CMD17_CRC   = 8'h95;
   localparam logic [7:0] TOKEN_START = 8'hFE;
   localparam logic [7:0] IDLE_BYTE   = 8'hFF;

   function automatic logic [7:0] cmd_byte(
      input logic [2:0]  idx,
      input logic [31:0] addr
   );
      case (idx)
         3'd0:    return CMD17;
         3'd1:    return addr[31:24];
         3'd2:    return addr[23:16];
         3'd3:    return addr[15:8];
         3'd4:    return addr[7:0];
         3'd5:    return CMD17_CRC;
         default: return IDLE_BYTE;
      endcase
   endfunction

endpackage

// File: rtl/sd_xfer_step.sv
// One sd unit action: issue strobe, guard cycle, then wait for
// the unit to go idle and capture the received byte and timeout.
module sd_xfer_step
   import sd_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req,
   input  sd_op_e     cmd,
   input  logic [7:0] tx_byte,
   output logic       ack,
   output logic [7:0] din,
   output logic       timeout,
   output logic       sd_signal,
   output logic [1:0] sd_cmd,
   output logic [7:0] sd_out,
   input  logic [7:0] sd_din,
   input  logic       sd_busy,
   input  logic       sd_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GUARD,
      ST_WAIT
   } step_e;

   step_e st, st_n;
   logic  wait_exit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) st <= ST_IDLE;
      else          st <= st_n;
   end

   always_comb begin
      st_n = st;
      unique case (st)
         ST_IDLE:  if (req) st_n = ST_ISSUE;
         ST_ISSUE: st_n = ST_GUARD;
         ST_GUARD: st_n = ST_WAIT;
         ST_WAIT:  if (!sd_busy) st_n = ST_IDLE;
         default:  st_n = ST_IDLE;
      endcase
   end

   assign wait_exit = (st == ST_WAIT) && !sd_busy;
   assign sd_signal = (st == ST_ISSUE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sd_cmd  <= 2'd0;
         sd_out  <= IDLE_BYTE;
         ack     <= 1'b0;
         din     <= 8'h00;
         timeout <= 1'b0;
      end else begin
         ack <= wait_exit;
         if (st == ST_IDLE && req) begin
            sd_cmd <= cmd;
            sd_out <= tx_byte;
         end
         if (wait_exit) begin
            din     <= sd_din;
            timeout <= sd_timeout;
         end
      end
   end

endmodule

// File: rtl/sd_sector_reader.sv
// CMD17 single-block read sequencer: drives the sd byte engine and
// streams the 512 data bytes of one sector into a buffer RAM.
module sd_sector_reader
   import sd_pkg::*;
#(
   parameter int RESP_TRIES  = 8,
   parameter int TOKEN_TRIES = 4096
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] lba,
   input  logic        sdhc,
   output logic        busy,
   output logic        done,
   output logic [2:0]  error,
   output logic [7:0]  r1,
   output logic        sd_signal,
   output logic [1:0]  sd_cmd,
   output logic [7:0]  sd_out,
   input  logic [7:0]  sd_din,
   input  logic        sd_busy,
   input  logic        sd_timeout,
   output logic [8:0]  buf_addr,
   output logic [7:0]  buf_data,
   output logic        buf_we
);

   localparam logic [12:0] RESP_LAST  = 13'(RESP_TRIES - 1);
   localparam logic [12:0] TOKEN_LAST = 13'(TOKEN_TRIES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CSLO,
      S_CMD,
      S_RESP,
      S_TOKEN,
      S_DATA,
      S_CRC,
      S_CS_HI,
      S_TAIL,
      S_FIN
   } state_e;

   state_e      state, state_n;
   logic [2:0]  cnt, cnt_n;
   logic [12:0] tries, tries_n;
   logic [9:0]  dcnt, dcnt_n;
   logic [31:0] addr, addr_n;
   err_e        err_q, err_n;
   err_e        error_q, error_n;
   logic [7:0]  r1_q, r1_n;

   logic        req;
   sd_op_e      req_cmd;
   logic [7:0]  req_byte;
   logic        ack;
   logic [7:0]  din;
   logic        timeout;

   sd_xfer_step u_step (
      .clock      (clock),
      .reset_n    (reset_n),
      .req        (req),
      .cmd        (req_cmd),
      .tx_byte    (req_byte),
      .ack        (ack),
      .din        (din),
      .timeout    (timeout),
      .sd_signal  (sd_signal),
      .sd_cmd     (sd_cmd),
      .sd_out     (sd_out),
      .sd_din     (sd_din),
      .sd_busy    (sd_busy),
      .sd_timeout (sd_timeout)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         cnt     <= 3'd0;
         tries   <= 13'd0;
         dcnt    <= 10'd0;
         addr    <= 32'd0;
         err_q   <= ERR_OK;
         error_q <= ERR_OK;
         r1_q    <= 8'h00;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         tries   <= tries_n;
         dcnt    <= dcnt_n;
         addr    <= addr_n;
         err_q   <= err_n;
         error_q <= error_n;
         r1_q    <= r1_n;
      end
   end

   // Each ack immediately issues the next action, chosen from the next state.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      tries_n = tries;
      dcnt_n  = dcnt;
      addr_n  = addr;
      err_n   = err_q;
      error_n = error_q;
      r1_n    = r1_q;
      req     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_CSLO;
               addr_n  = sdhc ? lba : {lba[22:0], 9'd0};
               err_n   = ERR_OK;
               error_n = ERR_OK;
               dcnt_n  = 10'd0;
               req     = 1'b1;
            end
         end
         S_FIN: state_n = S_IDLE;
         default: begin
            if (ack) begin
               if (timeout && !(state inside {S_CS_HI, S_TAIL})) begin
                  err_n   = ERR_SPI_TMO;
                  state_n = S_CS_HI;
               end else begin
                  if (timeout && err_q == ERR_OK) err_n = ERR_SPI_TMO;
                  case (state)
                     S_CSLO: begin
                        state_n = S_CMD;
                        cnt_n   = 3'd0;
                     end
                     S_CMD: begin
                        if (cnt == 3'd5) begin
                           state_n = S_RESP;
                           tries_n = 13'd0;
                        end else begin
                           cnt_n = cnt + 3'd1;
                        end
                     end
                     S_RESP: begin
                        if (!din[7]) begin
                           r1_n = din;
                           if (din != 8'h00) begin
                              err_n   = ERR_R1;
                              state_n = S_CS_HI;
                           end else begin
                              state_n = S_TOKEN;
                              tries_n = 13'd0;
                           end
                        end else if (tries == RESP_LAST) begin
                           err_n   = ERR_NO_R1;
                           state_n = S_CS_HI;
                        end else begin
                           tries_n = tries + 13'd1;
                        end
                     end
                     S_TOKEN: begin
                        if (din == TOKEN_START) begin
                           state_n = S_DATA;
                           dcnt_n  = 10'd0;
                        end else if (din != IDLE_BYTE) begin
                           err_n   = ERR_TOKEN;
                           state_n = S_CS_HI;
                        end else if (tries == TOKEN_LAST) begin
                           err_n   = ERR_TOKEN_TMO;
                           state_n = S_CS_HI;
                        end else begin
                           tries_n = tries + 13'd1;
                        end
                     end
                     S_DATA: begin
                        dcnt_n = dcnt + 10'd1;
                        if (dcnt == 10'd511) begin
                           state_n = S_CRC;
                           cnt_n   = 3'd0;
                        end
                     end
                     S_CRC: begin
                        if (cnt == 3'd1) state_n = S_CS_HI;
                        else             cnt_n = cnt + 3'd1;
                     end
                     S_CS_HI: state_n = S_TAIL;
                     S_TAIL: begin
                        state_n = S_FIN;
                        error_n = err_n;
                     end
                     default: state_n = S_IDLE;
                  endcase
               end
               req = (state_n != S_FIN);
            end
         end
      endcase
   end

   always_comb begin
      req_cmd  = SD_XFER;
      req_byte = IDLE_BYTE;
      unique case (1'b1)
         state_n == S_CSLO:  req_cmd = SD_CSLO;
         state_n == S_CS_HI: req_cmd = SD_CSHI;
         state_n == S_CMD:   req_byte = cmd_byte(cnt_n, addr_n);
         default:            req_cmd = SD_XFER;
      endcase
   end

   assign busy     = (state != S_IDLE) && (state != S_FIN);
   assign done     = (state == S_FIN);
   assign error    = error_q;
   assign r1       = r1_q;
   assign buf_addr = dcnt[8:0];
   assign buf_data = din;
   assign buf_we   = (state == S_DATA) && ack && !timeout;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Randomized bench: sd unit + card model, buffer model and a
// transaction-level reference for error code, traffic and data.
module tb_sd_sector_reader;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        sdhc = 1'b0;
   logic [31:0] lba = 32'd0;
   logic        busy, done;
   logic [2:0]  error;
   logic [7:0]  r1;
   logic        sd_signal;
   logic [1:0]  sd_cmd;
   logic [7:0]  sd_out;
   logic [7:0]  sd_din;
   logic        sd_busy, sd_timeout;
   logic [8:0]  buf_addr;
   logic [7:0]  buf_data;
   logic        buf_we;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   sd_sector_reader #(.RESP_TRIES(8), .TOKEN_TRIES(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .lba        (lba),
      .sdhc       (sdhc),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .r1         (r1),
      .sd_signal  (sd_signal),
      .sd_cmd     (sd_cmd),
      .sd_out     (sd_out),
      .sd_din     (sd_din),
      .sd_busy    (sd_busy),
      .sd_timeout (sd_timeout),
      .buf_addr   (buf_addr),
      .buf_data   (buf_data),
      .buf_we     (buf_we)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // card scenario
   int         gap_r1, gap_tok, tmo_at;
   logic [7:0] r1_val, tok_val;
   logic [7:0] card_data[512];

   // sd unit + card model
   logic [7:0] rq[$];
   logic [7:0] mosi[$];
   int         bcnt;
   logic [1:0] p_cmd;
   logic [7:0] p_out;
   logic       cs_low;
   int         cs_lo_cnt, cs_hi_cnt, sig_viol;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sd_busy    <= 1'b0;
         sd_din     <= 8'hFF;
         sd_timeout <= 1'b0;
         cs_low = 1'b0;
         bcnt = 0;
         rq.delete();
      end else if (sd_signal) begin
         if (sd_busy) sig_viol++;
         sd_busy <= 1'b1;
         bcnt = $urandom_range(1, 3);
         p_cmd = sd_cmd;
         p_out = sd_out;
      end else if (sd_busy) begin
         bcnt--;
         if (bcnt == 0) begin
            sd_busy <= 1'b0;
            sd_timeout <= 1'b0;
            if (p_cmd == 2'd1) begin
               cs_low = 1'b1;
               cs_lo_cnt++;
               mosi.delete();
               rq.delete();
            end else if (p_cmd == 2'd2) begin
               cs_low = 1'b0;
               cs_hi_cnt++;
            end else begin
               mosi.push_back(p_out);
               sd_timeout <= (mosi.size() == tmo_at);
               if (rq.size() > 0) sd_din <= rq.pop_front();
               else               sd_din <= 8'hFF;
               if (mosi.size() == 6) begin
                  for (int i = 0; i < gap_r1; i++) rq.push_back(8'hFF);
                  rq.push_back(r1_val);
                  for (int i = 0; i < gap_tok; i++) rq.push_back(8'hFF);
                  rq.push_back(tok_val);
                  if (tok_val == 8'hFE) begin
                     for (int i = 0; i < 512; i++) rq.push_back(card_data[i]);
                     rq.push_back(8'($urandom));
                     rq.push_back(8'($urandom));
                  end
               end
            end
         end
      end
   end

   // buffer + done monitors
   logic [7:0] mem[512];
   int         we_cnt, addr_bad, done_cnt;
   logic [2:0] err_at_done;
   logic       busy_at_done;

   always @(negedge clock) begin
      if (buf_we) begin
         if (buf_addr != we_cnt[8:0]) addr_bad++;
         mem[buf_addr] = buf_data;
         we_cnt++;
      end
      if (done) begin
         done_cnt++;
         err_at_done = error;
         busy_at_done = busy;
      end
   end

   // reference model
   logic [7:0] cmdb[6];
   int         exp_err, exp_wr, exp_x, ncmd;
   logic [7:0] exp_r1 = 8'h00;

   task automatic predict(input logic [31:0] l, input logic s);
      logic [31:0] a;
      int nr, nt;
      a = s ? l : l << 9;
      cmdb = '{8'h51, a[31:24], a[23:16], a[15:8], a[7:0], 8'h95};
      exp_wr = 0;
      ncmd = 6;
      if (tmo_at > 0) begin
         exp_err = 5;
         exp_x = tmo_at + 1;
         ncmd = tmo_at;
      end else begin
         nr = gap_r1 + 1;
         if (nr > 8) begin
            exp_err = 1;
            exp_x = 6 + 8 + 1;
         end else begin
            exp_r1 = r1_val;
            nt = gap_tok + 1;
            if (r1_val != 8'h00) begin
               exp_err = 2;
               exp_x = 6 + nr + 1;
            end else if (nt > 16) begin
               exp_err = 3;
               exp_x = 6 + nr + 16 + 1;
            end else if (tok_val != 8'hFE) begin
               exp_err = 4;
               exp_x = 6 + nr + nt + 1;
            end else begin
               exp_err = 0;
               exp_wr = 512;
               exp_x = 6 + nr + nt + 512 + 2 + 1;
            end
         end
      end
   endtask

   task automatic scen(input int g1, input logic [7:0] rv, input int g2,
                       input logic [7:0] tv, input int tm, input bit pat);
      gap_r1 = g1;
      r1_val = rv;
      gap_tok = g2;
      tok_val = tv;
      tmo_at = tm;
      for (int i = 0; i < 512; i++)
         card_data[i] = pat ? (8'(i) ^ 8'h5A) : 8'($urandom);
   endtask

   task automatic pulse_start(input logic [31:0] l, input logic s);
      @(negedge clock);
      lba = l;
      sdhc = s;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run_txn(input string nm, input logic [31:0] l,
                          input logic s, input bit dbl);
      int n, dmm, mmm;
      logic [7:0] eb;
      we_cnt = 0;
      addr_bad = 0;
      done_cnt = 0;
      cs_lo_cnt = 0;
      cs_hi_cnt = 0;
      sig_viol = 0;
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      predict(l, s);
      pulse_start(l, s);
      chk({nm, ".busy_rise"}, busy, 1);
      if (dbl) begin
         repeat (5) @(negedge clock);
         lba = ~l;
         sdhc = ~s;
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      n = 0;
      while (!done && n < 20000) begin
         @(negedge clock);
         n++;
      end
      chk({nm, ".done_in_time"}, n < 20000, 1);
      repeat (4) @(negedge clock);
      chk({nm, ".err_at_done"}, err_at_done, exp_err);
      chk({nm, ".err_held"}, error, exp_err);
      chk({nm, ".r1"}, r1, exp_r1);
      chk({nm, ".done_pulses"}, done_cnt, 1);
      chk({nm, ".busy_at_done"}, busy_at_done, 0);
      chk({nm, ".busy_after"}, busy, 0);
      chk({nm, ".writes"}, we_cnt, exp_wr);
      chk({nm, ".addr_seq"}, addr_bad, 0);
      dmm = 0;
      if (exp_wr == 512)
         for (int i = 0; i < 512; i++)
            if (mem[i] !== card_data[i]) dmm++;
      chk({nm, ".data"}, dmm, 0);
      chk({nm, ".xfers"}, mosi.size(), exp_x);
      mmm = 0;
      for (int i = 0; i < mosi.size(); i++) begin
         eb = (i < ncmd) ? cmdb[i] : 8'hFF;
         if (mosi[i] !== eb) mmm++;
      end
      chk({nm, ".mosi"}, mmm, 0);
      chk({nm, ".cs_cycle"}, {cs_low, 8'(cs_lo_cnt), 8'(cs_hi_cnt)},
          {1'b0, 8'd1, 8'd1});
      chk({nm, ".sig_viol"}, sig_viol, 0);
   endtask

   logic [41:0] rst_vec;
   assign rst_vec = {busy, done, sd_signal, buf_we, error, r1, sd_cmd,
                     buf_addr, sd_out, buf_data};
   localparam logic [41:0] RST_EXP = {4'b0000, 3'd0, 8'd0, 2'd0, 9'd0,
                                      8'hFF, 8'd0};

   initial begin
      int n, k;
      logic [7:0] tv;
      cs_lo_cnt = 0;
      cs_hi_cnt = 0;
      sig_viol = 0;
      scen(0, 8'h00, 0, 8'hFE, 0, 1'b1);
      repeat (3) @(negedge clock);
      chk("reset_values", rst_vec, RST_EXP);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      scen(1, 8'h00, 3, 8'hFE, 0, 1'b1);
      run_txn("byte_addr", 32'h0000_0003, 1'b0, 1'b0);
      scen(0, 8'h00, 0, 8'hFE, 0, 1'b0);
      run_txn("block_addr", 32'h1234_5678, 1'b1, 1'b0);
      scen(2, 8'h04, 0, 8'hFE, 0, 1'b0);
      run_txn("r1_err", $urandom, 1'b1, 1'b0);
      scen(100, 8'h00, 0, 8'hFE, 0, 1'b0);
      run_txn("no_r1", $urandom, 1'b0, 1'b0);
      scen(7, 8'h00, 100, 8'hFE, 0, 1'b0);
      run_txn("tok_tmo", $urandom, 1'b1, 1'b0);
      scen(0, 8'h00, 15, 8'hFE, 0, 1'b0);
      run_txn("tok_last", $urandom, 1'b0, 1'b0);
      scen(1, 8'h00, 2, 8'h08, 0, 1'b0);
      run_txn("err_tok", $urandom, 1'b1, 1'b0);
      scen(0, 8'h00, 0, 8'hFE, 3, 1'b0);
      run_txn("spi_tmo", $urandom, 1'b0, 1'b0);
      scen(3, 8'h00, 5, 8'hFE, 0, 1'b0);
      run_txn("dbl_start", $urandom, 1'b0, 1'b1);

      for (int t = 0; t < 4; t++) begin
         k = $urandom_range(0, 4);
         tv = 8'($urandom_range(0, 253));
         case (k)
            0: scen($urandom_range(8, 12), 8'h00, 0, 8'hFE, 0, 1'b0);
            1: scen($urandom_range(0, 7), 8'($urandom_range(1, 127)), 0,
                    8'hFE, 0, 1'b0);
            2: scen($urandom_range(0, 7), 8'h00, $urandom_range(0, 15),
                    tv, 0, 1'b0);
            3: scen(0, 8'h00, 0, 8'hFE, $urandom_range(1, 6), 1'b0);
            default: scen($urandom_range(0, 7), 8'h00,
                          $urandom_range(0, 15), 8'hFE, 0, 1'b0);
         endcase
         run_txn("rand", $urandom, 1'($urandom), 1'b0);
      end

      scen(0, 8'h00, 1, 8'hFE, 0, 1'b0);
      we_cnt = 0;
      pulse_start($urandom, 1'b1);
      n = 0;
      while (we_cnt < 100 && n < 20000) begin
         @(negedge clock);
         n++;
      end
      chk("rst_mid.reach_data", n < 20000, 1);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1 chk("rst_mid.outputs", rst_vec, RST_EXP);
      exp_r1 = 8'h00;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      scen(2, 8'h00, 4, 8'hFE, 0, 1'b0);
      run_txn("after_rst", $urandom, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
